// File: rtl/rv32i_defs.sv
// rv32i_defs: definitions shared by the RV32I front end.
// Holds the base opcodes, the immediate-type select encoding used by the
// fetch pre-decode, the ImmediateExtractor and the decoder, the canonical
// NOP word, and the fetch FSM state encoding.
package rv32i_defs;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    // Immediate-type select, consumed directly by the ImmediateExtractor
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_U    = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_UJ   = 3'd5
    } imm_sel_e;

    // addi x0,x0,0
    localparam logic [31:0] RV32I_NOP_WORD = 32'h00000013;

    // Fetch FSM: FETCH issues a request, WAIT awaits the response,
    // FULL means the skid buffer holds a word decode could not take.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: request/response bus between the fetch stage
// and instruction memory. One request at a time; the response strobe comes
// one or more cycles after the request pulse.
//   req    : one-cycle request pulse (fetch -> memory)
//   addr   : fetch address, valid while req=1
//   rvalid : response strobe (memory -> fetch)
//   rdata  : instruction word, valid with rvalid
interface instruction_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/imm_sel_decoder.sv
// imm_sel_decoder: combinational opcode pre-decode shared by fetch and decode.
//   opcode  in  7  inst[6:0]
//   imm_sel out 3  immediate type for the ImmediateExtractor
//   illegal out 1  opcode is not part of RV32I (includes inst[1:0]!=2'b11)
module imm_sel_decoder
    import rv32i_defs::*;
(
    input  logic [6:0] opcode,
    output imm_sel_e   imm_sel,
    output logic       illegal
);

    always_comb begin
        imm_sel = IMM_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: imm_sel = IMM_I;
            OP_LUI, OP_AUIPC:                                 imm_sel = IMM_U;
            OP_STORE:                                         imm_sel = IMM_S;
            OP_BRANCH:                                        imm_sel = IMM_B;
            OP_JAL:                                           imm_sel = IMM_UJ;
            OP_REG:                                           imm_sel = IMM_NONE;
            default:                                          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RV32I fetch stage.
// Owns the PC, issues one outstanding request at a time to instruction
// memory, and registers the returned word with its PC and pre-decoded
// immediate select into the IF/ID register behind a one-entry skid buffer.
// Ports:
//   clk, reset_n          clock; synchronous active-low reset
//   imem                  instruction memory bus (master side)
//   stall                 decode cannot accept; ID outputs hold
//   redirect, redirect_pc taken branch/jump and its target (highest priority)
//   id_valid              ID outputs hold a live instruction
//   id_instruction/id_pc  instruction word and its address
//   id_imm_sel/id_illegal pre-decode results for id_instruction
module instruction_fetch_stage
    import rv32i_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_WORD = RV32I_NOP_WORD
) (
    input  logic                       clk,
    input  logic                       reset_n,
    instruction_fetch_stage_if.master  imem,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    output logic [31:0]                id_instruction,
    output logic [31:0]                id_pc,
    output logic [2:0]                 id_imm_sel,
    output logic                       id_illegal
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         kill_reg, kill_next;
    logic [31:0]  skid_inst_reg, skid_inst_next;
    logic [31:0]  skid_pc_reg, skid_pc_next;
    logic         id_valid_reg, id_valid_next;
    logic [31:0]  id_inst_reg, id_inst_next;
    logic [31:0]  id_pc_reg, id_pc_next;
    imm_sel_e     id_imm_sel_reg, id_imm_sel_next;
    logic         id_illegal_reg, id_illegal_next;

    logic         accept;
    logic         id_can_load;
    logic         skid_full;
    logic         outstanding;
    logic [31:0]  load_inst;
    logic [31:0]  load_pc;
    imm_sel_e     dec_imm_sel;
    logic         dec_illegal;

    // Gating with reset_n keeps req low while reset is held even though the
    // state register already sits in FETCH.
    assign imem.req  = (state_reg == ST_FETCH) && reset_n;
    assign imem.addr = pc_reg;

    assign skid_full   = (state_reg == ST_FULL);
    assign accept      = (state_reg == ST_WAIT) && imem.rvalid && !kill_reg;
    assign id_can_load = !id_valid_reg || !stall;
    // A request issued this cycle, or one still waiting, will be answered later.
    assign outstanding = (state_reg == ST_FETCH) ||
                         ((state_reg == ST_WAIT) && !imem.rvalid);

    // Skid has priority: it can only be full when no response is accepted.
    assign load_inst = skid_full ? skid_inst_reg : imem.rdata;
    assign load_pc   = skid_full ? skid_pc_reg   : pc_reg;

    imm_sel_decoder u_imm_sel_decoder (
        .opcode  (load_inst[6:0]),
        .imm_sel (dec_imm_sel),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        kill_next       = kill_reg;
        skid_inst_next  = skid_inst_reg;
        skid_pc_next    = skid_pc_reg;
        id_valid_next   = id_valid_reg;
        id_inst_next    = id_inst_reg;
        id_pc_next      = id_pc_reg;
        id_imm_sel_next = id_imm_sel_reg;
        id_illegal_next = id_illegal_reg;

        if (redirect) begin
            pc_next         = redirect_pc;
            id_valid_next   = 1'b0;
            id_inst_next    = NOP_WORD;
            id_imm_sel_next = IMM_NONE;
            id_illegal_next = 1'b0;
            // Skid contents are simply abandoned by leaving FULL.
            if (outstanding) begin
                kill_next  = 1'b1;
                state_next = ST_WAIT;
            end else begin
                kill_next  = 1'b0;
                state_next = ST_FETCH;
            end
        end else begin
            case (state_reg)
                ST_FETCH: state_next = ST_WAIT;
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        if (kill_reg) begin
                            // Stale response from before a redirect.
                            kill_next  = 1'b0;
                            state_next = ST_FETCH;
                        end else begin
                            pc_next = pc_reg + 32'd4;
                            if (id_can_load) begin
                                state_next = ST_FETCH;
                            end else begin
                                state_next     = ST_FULL;
                                skid_inst_next = imem.rdata;
                                skid_pc_next   = pc_reg;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (id_can_load) state_next = ST_FETCH;
                end
                default: state_next = ST_FETCH;
            endcase

            if (id_can_load) begin
                if (skid_full || accept) begin
                    id_valid_next   = 1'b1;
                    id_inst_next    = load_inst;
                    id_pc_next      = load_pc;
                    id_imm_sel_next = dec_imm_sel;
                    id_illegal_next = dec_illegal;
                end else begin
                    id_valid_next   = 1'b0;
                    id_inst_next    = NOP_WORD;
                    id_imm_sel_next = IMM_NONE;
                    id_illegal_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            kill_reg       <= 1'b0;
            skid_inst_reg  <= NOP_WORD;
            skid_pc_reg    <= 32'h0;
            id_valid_reg   <= 1'b0;
            id_inst_reg    <= NOP_WORD;
            id_pc_reg      <= 32'h0;
            id_imm_sel_reg <= IMM_NONE;
            id_illegal_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            kill_reg       <= kill_next;
            skid_inst_reg  <= skid_inst_next;
            skid_pc_reg    <= skid_pc_next;
            id_valid_reg   <= id_valid_next;
            id_inst_reg    <= id_inst_next;
            id_pc_reg      <= id_pc_next;
            id_imm_sel_reg <= id_imm_sel_next;
            id_illegal_reg <= id_illegal_next;
        end
    end

    assign id_valid       = id_valid_reg;
    assign id_instruction = id_inst_reg;
    assign id_pc          = id_pc_reg;
    assign id_imm_sel     = id_imm_sel_reg;
    assign id_illegal     = id_illegal_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a variable-latency
// instruction memory model.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;

    int n_cmp = 0;
    int n_mis = 0;
    int mem_lat = 1;

    logic [31:0] imem [0:127];
    int          mem_cnt = 0;
    logic        mem_req_seen;
    logic [31:0] mem_addr_seen;
    logic [31:0] mem_paddr = 32'h0;

    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0] stream_word [1:6] = '{32'h00001337, 32'h00B323A3, 32'hFEC5CAE3,
                                       32'h4000006F, 32'h00B50533, 32'hFFFFFFFF};
    logic [2:0]  stream_sel  [1:6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};
    logic        stream_ill  [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    instruction_fetch_stage_if imem_bus ();

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem           (imem_bus),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_imm_sel     (id_imm_sel),
        .id_illegal     (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("  ok  %s = %08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [2:0] sel, input logic ill);
        chk({tag, " id_valid"}, 32'(id_valid), 32'd1);
        chk({tag, " id_pc"}, id_pc, pc);
        chk({tag, " id_inst"}, id_instruction, inst);
        chk({tag, " id_imm_sel"}, 32'(id_imm_sel), 32'(sel));
        chk({tag, " id_illegal"}, 32'(id_illegal), 32'(ill));
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, " req"}, 32'(imem_bus.req), 32'(req));
        if (req) chk({tag, " addr"}, imem_bus.addr, addr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, " id_inst"}, id_instruction, NOP);
        chk({tag, " id_pc"}, id_pc, 32'h0);
        chk({tag, " id_imm_sel"}, 32'(id_imm_sel), 32'd0);
        chk({tag, " id_illegal"}, 32'(id_illegal), 32'd0);
        chk({tag, " req"}, 32'(imem_bus.req), 32'd0);
    endtask

    // Memory: samples the request mid-cycle and answers mem_lat cycles later.
    initial begin
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = 32'h0;
        forever begin
            @(negedge clk);
            mem_req_seen  = imem_bus.req;
            mem_addr_seen = imem_bus.addr;
            @(posedge clk);
            #1;
            imem_bus.rvalid = 1'b0;
            if (mem_req_seen === 1'b1) begin
                mem_cnt   = mem_lat;
                mem_paddr = mem_addr_seen;
            end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_bus.rvalid = 1'b1;
                    imem_bus.rdata  = imem[mem_paddr[8:2]];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = NOP;
        imem[0]  = 32'h00A00613;
        for (int k = 1; k <= 6; k++) imem[k] = stream_word[k];
        imem[32] = 32'h00208113;
        imem[33] = 32'h00500193;
        imem[64] = 32'h00100093;
        imem[65] = 32'h00200113;

        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk_reset_outputs("reset");

        // Basic fetch with 1-cycle memory
        reset_n = 1'b1; #1;
        chk_req("c1", 1'b1, 32'h0);
        tick();
        chk_req("c2", 1'b0, 32'h0);
        chk("c2 id_valid", 32'(id_valid), 32'd0);
        tick();
        chk_id("c3", 32'h0, 32'h00A00613, 3'd1, 1'b0);
        chk_req("c3", 1'b1, 32'h4);

        // Immediate-type stream
        for (int k = 1; k <= 6; k++) begin
            chk_req($sformatf("stream%0d", k), 1'b1, 32'(4 * k));
            tick(); tick();
            chk_id($sformatf("stream%0d", k), 32'(4 * k), stream_word[k], stream_sel[k], stream_ill[k]);
        end

        // Stall with skid buffer
        reset_n = 1'b0; tick(); reset_n = 1'b1; #1;
        chk_req("stall c1", 1'b1, 32'h0);
        tick(); tick();
        chk_id("stall c3", 32'h0, 32'h00A00613, 3'd1, 1'b0);
        stall = 1'b1;
        for (int c = 4; c <= 8; c++) begin
            tick();
            chk($sformatf("stall c%0d req", c), 32'(imem_bus.req), 32'd0);
            chk($sformatf("stall c%0d id_pc", c), id_pc, 32'h0);
            chk($sformatf("stall c%0d id_inst", c), id_instruction, 32'h00A00613);
            chk($sformatf("stall c%0d id_valid", c), 32'(id_valid), 32'd1);
        end
        stall = 1'b0;
        tick();
        chk_id("skid drain", 32'h4, 32'h00001337, 3'd2, 1'b0);
        chk_req("skid drain", 1'b1, 32'h8);

        // Redirect while a 3-cycle request is outstanding
        mem_lat = 3;
        tick();
        chk("redir c10 id_valid", 32'(id_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h00000100;
        tick();
        redirect = 1'b0;
        chk("redir c11 id_valid", 32'(id_valid), 32'd0);
        chk("redir c11 id_inst", id_instruction, NOP);
        chk_req("redir c11", 1'b0, 32'h0);
        tick();
        chk_req("redir c12", 1'b0, 32'h0);
        tick();
        chk_req("redir c13", 1'b1, 32'h100);
        chk("redir c13 id_valid", 32'(id_valid), 32'd0);
        mem_lat = 1;
        tick(); tick();
        chk_id("redir target", 32'h100, 32'h00100093, 3'd1, 1'b0);
        chk_req("redir target", 1'b1, 32'h104);

        // Redirect, stall and response in the same cycle
        stall = 1'b1;
        tick();
        chk_id("combo hold", 32'h100, 32'h00100093, 3'd1, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h00000080;
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk("combo id_valid", 32'(id_valid), 32'd0);
        chk("combo id_inst", id_instruction, NOP);
        chk_req("combo", 1'b1, 32'h80);
        tick(); tick();
        chk_id("combo target", 32'h80, 32'h00208113, 3'd1, 1'b0);
        chk_req("combo target", 1'b1, 32'h84);

        // Reset while waiting on a slow response
        mem_lat = 3;
        tick();
        chk_req("rstwait c20", 1'b0, 32'h0);
        reset_n = 1'b0;
        tick();
        chk_reset_outputs("rstwait");
        mem_lat = 1;
        tick();
        reset_n = 1'b1; #1;
        chk_req("restart", 1'b1, 32'h0);
        tick();
        chk("late rvalid id_valid", 32'(id_valid), 32'd0);
        tick();
        chk_id("restart", 32'h0, 32'h00A00613, 3'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
Fetch stage of the RV32I core. It owns the PC and issues one-at-a-time requests to instruction memory, which may take a variable number of cycles to respond. It registers the returned word with its PC into the IF/ID register, behind a one-entry skid buffer. It pre-decodes the opcode into the 3-bit immediate-type select consumed directly by the ImmediateExtractor, and honours downstream stall and branch/jump redirect.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset.
NOP_WORD, 32'h00000013, ID_INSTRUCTION value when no valid instruction is held (addi x0,x0,0).

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  reset, synchronous, active-low
IMEM_REQ  out  1  one-cycle request pulse
IMEM_ADDR  out  32  fetch address; valid while IMEM_REQ=1
IMEM_RVALID  in  1  response strobe; arrives 1..N cycles after IMEM_REQ
IMEM_RDATA  in  32  instruction word; valid with IMEM_RVALID
STALL  in  1  decode cannot accept; hold ID_* outputs
REDIRECT  in  1  taken branch/jump; highest priority
REDIRECT_PC  in  32  new PC; word-aligned
ID_VALID  out  1  ID_* outputs hold a live instruction
ID_INSTRUCTION  out  32  instruction to decode / ImmediateExtractor INSTRUCTION
ID_PC  out  32  address of ID_INSTRUCTION
ID_IMM_SEL  out  3  ImmediateExtractor SELECTION: 0 none, 1 I, 2 U, 3 S, 4 B, 5 UJ
ID_ILLEGAL  out  1  opcode not RV32I, or inst[1:0]!=2'b11

Behaviour:
- Reset (RESET_N=0 at a clock edge) puts the block in this state:
  - PC=RESET_PC; state FETCH; KILL=0; skid buffer empty.
  - IMEM_REQ=0; ID_VALID=0; ID_INSTRUCTION=NOP_WORD; ID_PC=0; ID_IMM_SEL=0; ID_ILLEGAL=0.
  - Reset mid-request: the later response is ignored. The first IMEM_REQ comes in the first cycle after RESET_N rises.
- States:
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC for exactly one cycle, then go to WAIT.
  - WAIT: wait for IMEM_RVALID.
  - FULL: skid buffer occupied; no request is issued.
- Only one request is ever outstanding. IMEM_REQ=0 in WAIT and FULL.
- Response handling in WAIT with IMEM_RVALID=1 and KILL=0:
  - The word is accepted and PC <= PC+4.
  - If the ID register can load (ID_VALID=0 or STALL=0), the word goes to the ID register and the next state is FETCH.
  - Otherwise the word goes to the skid buffer and the next state is FULL.
- ID register load rule, in any cycle where ID_VALID=0 or STALL=0:
  - Load from the skid buffer if it is full, else from the accepted response.
  - If neither is available, ID_VALID <= 0 and ID_INSTRUCTION <= NOP_WORD.
  - FULL returns to FETCH in the cycle the skid buffer drains.
- STALL=1 with ID_VALID=1 holds all ID_* outputs bit-stable.
- Throughput: with a 1-cycle memory, one instruction every 2 cycles.
  - REQ at cycle t, RVALID at t+1, ID_VALID=1 from t+2, next REQ at t+2.
- REDIRECT=1 overrides STALL, state and response. At that edge:
  - PC <= REDIRECT_PC; ID_VALID <= 0; ID_INSTRUCTION <= NOP_WORD; skid buffer cleared.
  - A response arriving in the same cycle is discarded.
  - If a request is still outstanding, set KILL=1 and stay in WAIT; otherwise go to FETCH.
- KILL: the next IMEM_RVALID is dropped, KILL clears and the state goes to FETCH, so the redirected fetch follows. Any REQ issued after the redirect uses REDIRECT_PC.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- IMM_SEL decode from inst[6:0], registered together with ID_INSTRUCTION:
  - I (1): 0010011, 0000011, 1100111, 1110011, 0001111.
  - U (2): 0110111, 0010111.
  - S (3): 0100011.
  - B (4): 1100011.
  - UJ (5): 1101111.
  - R-type 0110011 gives 0 with ILLEGAL=0.
  - Any other opcode gives 0 with ILLEGAL=1.

Decomposition:
- Shared package rv32i_defs holds:
  - opcode constants;
  - IMM_SEL encodings (IMM_NONE=0, IMM_I=1, IMM_U=2, IMM_S=3, IMM_B=4, IMM_UJ=5), also used by ImmediateExtractor and the decoder;
  - the NOP_WORD constant;
  - FSM state encodings.
- One combinational sub-module, imm_sel_decoder (inst[6:0] -> IMM_SEL, ILLEGAL), shared with the decode stage.

Test Plan:
- Reset, then a 1-cycle memory returning 00A00613 at PC 0 -> REQ addr 0 at cycle 1, ID_VALID at cycle 3, ID_PC=0, ID_IMM_SEL=1, next REQ addr 4.
- Stream 00001337, 00B323A3, FEC5CAE3, 4000006F, 00B50533, FFFFFFFF -> IMM_SEL sequence 2,3,4,5,0,0; ID_ILLEGAL=1 only on FFFFFFFF; ID_PC increments by 4.
- STALL held 5 cycles while ID holds PC 0 and the response for PC 4 arrives -> outputs stable, skid used, no REQ issued; after STALL drops, PC 4 appears the next cycle and then REQ addr 8.
- REDIRECT to 0x00000100 while a 3-cycle-latency request for PC 8 is outstanding -> that response dropped, ID_VALID=0, next REQ addr 0x100, ID_PC=0x100.
- REDIRECT, STALL and IMEM_RVALID all in the same cycle -> response discarded, ID_VALID=0, fetch from REDIRECT_PC.
- RESET_N pulsed low while in WAIT -> all outputs take their reset values; the late RVALID is ignored; the fetch restarts at RESET_PC.
